// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS main control: opcodes, ALU
// select codes, FSM states and instruction classes.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [2:0] ALU_RTYPE = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_SLT   = 3'b111;
   localparam logic [2:0] ALU_SUB   = 3'b110;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_ALU_WB,
      S_MEM_ADDR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_BRANCH,
      S_TRAP
   } stateT;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_ALUI,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_BAD
   } instrClassT;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multi-cycle controller (master) and the datapath
// it steers (slave).
interface mips_multicycle_control_if #(
   parameter int OP_W  = 6,
   parameter int ALU_W = 3,
   parameter int CNT_W = 16
);
   logic [OP_W-1:0]  op;
   logic             alu_zero;
   logic             mem_ready;
   logic             ir_write;
   logic             pc_write;
   logic             pc_src;
   logic [ALU_W-1:0] aluSel;
   logic             aluSrc;
   logic             regDst;
   logic             regWrite;
   logic             memRead;
   logic             memWrite;
   logic             memToReg;
   logic             branch;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  op, alu_zero, mem_ready,
      output ir_write, pc_write, pc_src, aluSel, aluSrc, regDst, regWrite,
             memRead, memWrite, memToReg, branch, illegal, retired
   );

   modport slave (
      output op, alu_zero, mem_ready,
      input  ir_write, pc_write, pc_src, aluSel, aluSrc, regDst, regWrite,
             memRead, memWrite, memToReg, branch, illegal, retired
   );
endinterface

// File: rtl/mips_multicycle_control_classify.sv
// Combinational opcode decode into an instruction class and the ALU select
// code that class uses in its execute cycle.
module mips_op_classify
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W  = 6,
   parameter int ALU_W = 3
) (
   input  logic [OP_W-1:0]  op,
   output instrClassT       opClass,
   output logic [ALU_W-1:0] aluSel
);

   always_comb begin
      opClass = CLS_BAD;
      aluSel  = '0;
      case (op)
         OP_W'(OP_RTYPE): begin opClass = CLS_R;    aluSel = ALU_W'(ALU_RTYPE); end
         OP_W'(OP_ADDI):  begin opClass = CLS_ALUI; aluSel = ALU_W'(ALU_ADD);   end
         OP_W'(OP_ORI):   begin opClass = CLS_ALUI; aluSel = ALU_W'(ALU_OR);    end
         OP_W'(OP_ANDI):  begin opClass = CLS_ALUI; aluSel = ALU_W'(ALU_AND);   end
         OP_W'(OP_SLTI):  begin opClass = CLS_ALUI; aluSel = ALU_W'(ALU_SLT);   end
         OP_W'(OP_LW):    begin opClass = CLS_LW;   aluSel = ALU_W'(ALU_ADD);   end
         OP_W'(OP_SW):    begin opClass = CLS_SW;   aluSel = ALU_W'(ALU_ADD);   end
         OP_W'(OP_BEQ):   begin opClass = CLS_BEQ;  aluSel = ALU_W'(ALU_SUB);   end
         default:         begin opClass = CLS_BAD;  aluSel = '0;                end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control: sequences fetch/decode/execute/memory/
// write-back, stalls on mem_ready, flags illegal opcodes, counts retirements.
module mips_multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W  = 6,
   parameter int ALU_W = 3,
   parameter int CNT_W = 16
) (
   input logic                   clk,
   input logic                   rst,
   mips_multicycle_control_if.master bus
);

   stateT            state, nextState;
   instrClassT       decClass, classReg;
   logic [ALU_W-1:0] decAlu, aluReg;
   logic [CNT_W-1:0] retiredCnt;
   logic             illegalReg;
   logic             retireNow;

   mips_op_classify #(.OP_W(OP_W), .ALU_W(ALU_W)) uClassify (
      .op      (bus.op),
      .opClass (decClass),
      .aluSel  (decAlu)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= nextState;
   end

   // op is only trusted in DECODE; later states read the latched copy
   always_ff @(posedge clk) begin
      if (rst) begin
         classReg <= CLS_R;
         aluReg   <= '0;
      end else if (state == S_DECODE) begin
         classReg <= decClass;
         aluReg   <= decAlu;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         retiredCnt <= '0;
         illegalReg <= 1'b0;
      end else begin
         if (retireNow) retiredCnt <= retiredCnt + CNT_W'(1);
         if (state == S_DECODE && decClass == CLS_BAD) illegalReg <= 1'b1;
      end
   end

   always_comb begin
      nextState = state;
      retireNow = 1'b0;
      case (state)
         S_FETCH:     if (bus.mem_ready) nextState = S_DECODE;
         S_DECODE: begin
            case (decClass)
               CLS_R, CLS_ALUI: nextState = S_EXEC;
               CLS_LW, CLS_SW:  nextState = S_MEM_ADDR;
               CLS_BEQ:         nextState = S_BRANCH;
               default:         nextState = S_TRAP;
            endcase
         end
         S_EXEC:      nextState = S_ALU_WB;
         S_ALU_WB: begin
            nextState = S_FETCH;
            retireNow = 1'b1;
         end
         S_MEM_ADDR:  nextState = (classReg == CLS_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (bus.mem_ready) nextState = S_MEM_WB;
         S_MEM_WB: begin
            nextState = S_FETCH;
            retireNow = 1'b1;
         end
         S_MEM_WRITE: begin
            if (bus.mem_ready) begin
               nextState = S_FETCH;
               retireNow = 1'b1;
            end
         end
         S_BRANCH: begin
            nextState = S_FETCH;
            retireNow = 1'b1;
         end
         S_TRAP:      nextState = S_FETCH;
         default:     nextState = S_FETCH;
      endcase
   end

   always_comb begin
      bus.ir_write = 1'b0;
      bus.pc_write = 1'b0;
      bus.pc_src   = 1'b0;
      bus.aluSel   = '0;
      bus.aluSrc   = 1'b0;
      bus.regDst   = 1'b0;
      bus.regWrite = 1'b0;
      bus.memRead  = 1'b0;
      bus.memWrite = 1'b0;
      bus.memToReg = 1'b0;
      bus.branch   = 1'b0;
      case (state)
         S_FETCH: begin
            bus.memRead  = 1'b1;
            bus.ir_write = bus.mem_ready;
            bus.pc_write = bus.mem_ready;
         end
         S_EXEC: begin
            bus.aluSel = aluReg;
            bus.aluSrc = (classReg != CLS_R);
         end
         S_ALU_WB: begin
            bus.aluSel   = aluReg;
            bus.aluSrc   = (classReg != CLS_R);
            bus.regWrite = 1'b1;
            bus.regDst   = (classReg == CLS_R);
         end
         S_MEM_ADDR: begin
            bus.aluSel = ALU_W'(ALU_ADD);
            bus.aluSrc = 1'b1;
         end
         S_MEM_READ: begin
            bus.memRead = 1'b1;
            bus.aluSel  = ALU_W'(ALU_ADD);
            bus.aluSrc  = 1'b1;
         end
         S_MEM_WB: begin
            bus.regWrite = 1'b1;
            bus.memToReg = 1'b1;
         end
         S_MEM_WRITE: begin
            bus.memWrite = 1'b1;
            bus.aluSel   = ALU_W'(ALU_ADD);
            bus.aluSrc   = 1'b1;
         end
         S_BRANCH: begin
            bus.branch = 1'b1;
            bus.aluSel = ALU_W'(ALU_SUB);
            bus.pc_src = bus.alu_zero;
         end
         default: ;
      endcase
   end

   assign bus.illegal = illegalReg;
   assign bus.retired = retiredCnt;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: each cycle's expected outputs
// are queued when inputs are driven and compared at the following negedge.
module tb_mips_multicycle_control;

   localparam int OP_W  = 6;
   localparam int ALU_W = 3;
   localparam int CNT_W = 4;

   typedef enum int {T_F, T_D, T_EX, T_AWB, T_MA, T_MR, T_MWB, T_MW, T_BR, T_TR} tbStT;

   typedef struct packed {
      logic       irW;
      logic       pcW;
      logic       pcSrc;
      logic [2:0] aluSel;
      logic       aluSrc;
      logic       regDst;
      logic       regWrite;
      logic       memRead;
      logic       memWrite;
      logic       memToReg;
      logic       branch;
      logic       illegal;
      logic [3:0] retired;
   } outT;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mips_multicycle_control_if #(.OP_W(OP_W), .ALU_W(ALU_W), .CNT_W(CNT_W)) bus ();

   mips_multicycle_control #(.OP_W(OP_W), .ALU_W(ALU_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   outT        expQ[$];
   string      tagQ[$];
   int         checks = 0;
   int         errors = 0;
   logic [3:0] mRetired = '0;
   logic       mIllegal = 1'b0;

   function automatic outT observed();
      outT o;
      o = {bus.ir_write, bus.pc_write, bus.pc_src, bus.aluSel, bus.aluSrc, bus.regDst,
           bus.regWrite, bus.memRead, bus.memWrite, bus.memToReg, bus.branch,
           bus.illegal, bus.retired};
      return o;
   endfunction

   task automatic compareOne();
      outT   e, o;
      string t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      o = observed();
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
   endtask

   task automatic step(input tbStT st, input logic [5:0] opv, input logic mr, input logic az,
                       input logic [2:0] aluS, input logic isR, input string tag);
      outT e;
      e = '0;
      bus.op        = opv;
      bus.mem_ready = mr;
      bus.alu_zero  = az;
      case (st)
         T_F:   begin e.memRead = 1'b1; e.irW = mr; e.pcW = mr; end
         T_EX:  begin e.aluSel = aluS; e.aluSrc = ~isR; end
         T_AWB: begin e.aluSel = aluS; e.aluSrc = ~isR; e.regWrite = 1'b1; e.regDst = isR; end
         T_MA:  begin e.aluSel = 3'b010; e.aluSrc = 1'b1; end
         T_MR:  begin e.memRead = 1'b1; e.aluSel = 3'b010; e.aluSrc = 1'b1; end
         T_MWB: begin e.regWrite = 1'b1; e.memToReg = 1'b1; end
         T_MW:  begin e.memWrite = 1'b1; e.aluSel = 3'b010; e.aluSrc = 1'b1; end
         T_BR:  begin e.branch = 1'b1; e.aluSel = 3'b110; e.pcSrc = az; end
         default: ;
      endcase
      e.illegal = mIllegal;
      e.retired = mRetired;
      expQ.push_back(e);
      tagQ.push_back($sformatf("%s/%s", tag, st.name()));
      @(negedge clk);
      compareOne();
      @(posedge clk);
      if (rst) begin
         mRetired = '0;
         mIllegal = 1'b0;
      end else if (st == T_AWB || st == T_MWB || st == T_BR || (st == T_MW && mr)) begin
         mRetired = mRetired + 4'd1;
      end
      #1;
   endtask

   // op is driven to junk outside DECODE and mem_ready low in EXEC/ALU_WB;
   // neither may influence the sequence.
   task automatic runAlu(input logic [5:0] opv, input logic [2:0] aluS, input logic isR,
                         input int unsigned fetchStall, input string tag);
      for (int unsigned i = 0; i < fetchStall; i++) step(T_F, 6'h3F, 1'b0, 1'b0, aluS, isR, tag);
      step(T_F,   opv,   1'b1, 1'b1, aluS, isR, tag);
      step(T_D,   opv,   1'b1, 1'b1, aluS, isR, tag);
      step(T_EX,  6'h3F, 1'b0, 1'b1, aluS, isR, tag);
      step(T_AWB, 6'h04, 1'b0, 1'b1, aluS, isR, tag);
   endtask

   task automatic runLw(input int unsigned stalls, input string tag);
      step(T_F,  6'b100011, 1'b1, 1'b0, 3'b000, 1'b0, tag);
      step(T_D,  6'b100011, 1'b1, 1'b0, 3'b000, 1'b0, tag);
      step(T_MA, 6'b101011, 1'b1, 1'b0, 3'b000, 1'b0, tag);
      for (int unsigned i = 0; i < stalls; i++) step(T_MR, 6'h00, 1'b0, 1'b0, 3'b000, 1'b0, tag);
      step(T_MR,  6'h00, 1'b1, 1'b0, 3'b000, 1'b0, tag);
      step(T_MWB, 6'h00, 1'b0, 1'b0, 3'b000, 1'b0, tag);
   endtask

   task automatic runSwStart(input int unsigned stalls, input string tag);
      step(T_F,  6'b101011, 1'b1, 1'b0, 3'b000, 1'b0, tag);
      step(T_D,  6'b101011, 1'b1, 1'b0, 3'b000, 1'b0, tag);
      step(T_MA, 6'b100011, 1'b1, 1'b0, 3'b000, 1'b0, tag);
      for (int unsigned i = 0; i < stalls; i++) step(T_MW, 6'h00, 1'b0, 1'b0, 3'b000, 1'b0, tag);
   endtask

   task automatic runBeq(input logic az, input string tag);
      step(T_F,  6'b000100, 1'b1, 1'b1, 3'b000, 1'b0, tag);
      step(T_D,  6'b000100, 1'b1, 1'b1, 3'b000, 1'b0, tag);
      step(T_BR, 6'h00,     1'b1, az,   3'b000, 1'b0, tag);
   endtask

   task automatic runTrap(input logic [5:0] opv, input string tag);
      step(T_F, opv, 1'b1, 1'b0, 3'b000, 1'b0, tag);
      step(T_D, opv, 1'b1, 1'b0, 3'b000, 1'b0, tag);
      mIllegal = 1'b1;
      step(T_TR, 6'h00, 1'b1, 1'b0, 3'b000, 1'b0, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.op        = '0;
      bus.mem_ready = 1'b1;
      bus.alu_zero  = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mRetired = '0;
      mIllegal = 1'b0;

      runAlu(6'b000000, 3'b000, 1'b1, 0, "rtype");
      runLw(3, "lw");
      runBeq(1'b1, "beqTaken");
      runBeq(1'b0, "beqNotTaken");
      runTrap(6'b111111, "trap");
      runAlu(6'b001000, 3'b010, 1'b0, 0, "addiAfterTrap");
      runAlu(6'b001101, 3'b001, 1'b0, 2, "oriFetchStall");
      runAlu(6'b001100, 3'b011, 1'b0, 0, "andi");
      runAlu(6'b001010, 3'b111, 1'b0, 0, "slti");
      runSwStart(2, "sw");
      step(T_MW, 6'h00, 1'b1, 1'b0, 3'b000, 1'b0, "sw");
      runLw(0, "lwNoStall");

      runSwStart(1, "swReset");
      rst = 1'b1;
      step(T_MW, 6'h00, 1'b1, 1'b0, 3'b000, 1'b0, "swReset");
      rst = 1'b0;

      for (int unsigned n = 0; n < 17; n++) runAlu(6'b001000, 3'b010, 1'b0, 0, "addiWrap");
      @(negedge clk);
      checks++;
      assert (bus.retired === 4'd1) else begin
         errors++;
         $error("FAIL wrapCount observed=%0d expected=1", bus.retired);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
